// File: rtl/sd_sector_client.sv
// sd_sector_client: single-sector requester in front of the SD-image/SRAM bridge.
// Accepts one read or write command at a time, drives the request line on one
// drive slot, follows the sd_ack handshake and owns a 512-byte sector buffer.
//
// Optional feature: define SD_SECTOR_CLIENT_TIMEOUT_EN to add a 24-bit watchdog
// that aborts a command stuck in REQ/XFER after TIMEOUT_CYCLES clocks.
//
// Ports:
//   clk_i, reset_n_i       clock, asynchronous active-low reset
//   req_rd_i, req_wr_i     one-cycle command pulses (read has priority)
//   lba_i                  sector number, sampled on accept
//   busy_o, done_o, err_o  command status
//   host_addr_i/data_i/we_i, host_data_o   host buffer port (registered read)
//   sd_lba_o, sd_rd_o, sd_wr_o, sd_ack_i   bridge request handshake
//   sd_buff_addr_i/dout_i/wr_i, sd_buff_din_o   bridge buffer port
module sd_sector_client #(
   parameter int unsigned DRIVE          = 0,
   parameter logic [23:0] TIMEOUT_CYCLES = 24'd8000000
) (
   input  logic        clk_i,
   input  logic        reset_n_i,
   input  logic        req_rd_i,
   input  logic        req_wr_i,
   input  logic [31:0] lba_i,
   output logic        busy_o,
   output logic        done_o,
   output logic        err_o,
   input  logic [8:0]  host_addr_i,
   input  logic [7:0]  host_data_i,
   input  logic        host_we_i,
   output logic [7:0]  host_data_o,
   output logic [31:0] sd_lba_o,
   output logic [1:0]  sd_rd_o,
   output logic [1:0]  sd_wr_o,
   input  logic        sd_ack_i,
   input  logic [8:0]  sd_buff_addr_i,
   input  logic [7:0]  sd_buff_dout_i,
   input  logic        sd_buff_wr_i,
   output logic [7:0]  sd_buff_din_o
);

   typedef enum logic [1:0] {StIdle, StReq, StXfer, StDone} state_e;

   state_e      state_q, state_d;
   logic        op_wr_q, op_wr_d;
   logic [31:0] lba_q, lba_d;
   logic        err_q, err_d;
   logic [9:0]  byte_cnt_q, byte_cnt_d;
   logic [7:0]  host_rdata_q;
   logic        busy;
   logic        accept;
   logic        bridge_we;
   logic        timeout;
   logic        req_ack;
   logic [1:0]  rd_vec, wr_vec;

   logic [7:0]  mem [512];

   assign busy   = (state_q == StReq) || (state_q == StXfer);
   assign accept = (state_q == StIdle) && (req_rd_i || req_wr_i);

`ifdef SD_SECTOR_CLIENT_TIMEOUT_EN
   logic [23:0] wdog_q, wdog_d;
   logic        ack_block_q, ack_block_d;

   assign timeout = busy && (wdog_q == TIMEOUT_CYCLES - 24'd1);
   // After a timeout, an ack that is still (or becomes) high belongs to the
   // aborted command and must not be taken as the next command's ack.
   assign req_ack = sd_ack_i && !ack_block_q;

   always_comb begin
      wdog_d = wdog_q;
      if (accept) begin
         wdog_d = '0;
      end else if (busy) begin
         wdog_d = wdog_q + 24'd1;
      end
      ack_block_d = ack_block_q;
      if (timeout) begin
         ack_block_d = 1'b1;
      end else if (!sd_ack_i) begin
         ack_block_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         wdog_q      <= '0;
         ack_block_q <= 1'b0;
      end else begin
         wdog_q      <= wdog_d;
         ack_block_q <= ack_block_d;
      end
   end
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
   assign timeout = 1'b0;
   assign req_ack = sd_ack_i;
`endif

   always_comb begin
      state_d    = state_q;
      op_wr_d    = op_wr_q;
      lba_d      = lba_q;
      err_d      = err_q;
      byte_cnt_d = byte_cnt_q;
      bridge_we  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               op_wr_d    = !req_rd_i;
               lba_d      = lba_i;
               err_d      = 1'b0;
               byte_cnt_d = '0;
               state_d    = StReq;
            end
         end
         StReq: begin
            if (timeout) begin
               err_d   = 1'b1;
               state_d = StDone;
            end else if (req_ack) begin
               state_d = StXfer;
            end
         end
         StXfer: begin
            if (!op_wr_q && sd_buff_wr_i) begin
               bridge_we  = 1'b1;
               byte_cnt_d = byte_cnt_q + 10'd1;
            end
            if (timeout) begin
               err_d   = 1'b1;
               state_d = StDone;
            end else if (!sd_ack_i) begin
               // byte_cnt_d so a strobe in the final cycle still counts
               err_d   = !op_wr_q && (byte_cnt_d != 10'd512);
               state_d = StDone;
            end
         end
         StDone: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q      <= StIdle;
         op_wr_q      <= 1'b0;
         lba_q        <= '0;
         err_q        <= 1'b0;
         byte_cnt_q   <= '0;
         host_rdata_q <= '0;
      end else begin
         state_q      <= state_d;
         op_wr_q      <= op_wr_d;
         lba_q        <= lba_d;
         err_q        <= err_d;
         byte_cnt_q   <= byte_cnt_d;
         host_rdata_q <= mem[host_addr_i];
      end
   end

   // Bridge writes only happen while busy and host writes only while idle,
   // so the two write ports never collide.
   always_ff @(posedge clk_i) begin
      if (bridge_we) begin
         mem[sd_buff_addr_i] <= sd_buff_dout_i;
      end else if (host_we_i && !busy) begin
         mem[host_addr_i] <= host_data_i;
      end
   end

   always_comb begin
      rd_vec            = '0;
      wr_vec            = '0;
      rd_vec[DRIVE[0]]  = (state_q == StReq) && !op_wr_q;
      wr_vec[DRIVE[0]]  = (state_q == StReq) && op_wr_q;
   end

   assign sd_rd_o       = rd_vec;
   assign sd_wr_o       = wr_vec;
   assign sd_lba_o      = lba_q;
   assign busy_o        = busy;
   assign done_o        = (state_q == StDone);
   assign err_o         = err_q;
   assign host_data_o   = host_rdata_q;
   assign sd_buff_din_o = mem[sd_buff_addr_i];

endmodule

// File: tb/tb_sd_sector_client.sv
// Directed testbench for sd_sector_client (drive slot 0).
module tb_sd_sector_client;

   logic        clk_i = 1'b0;
   logic        reset_n_i = 1'b0;
   logic        req_rd_i = 1'b0;
   logic        req_wr_i = 1'b0;
   logic [31:0] lba_i = '0;
   logic        busy_o, done_o, err_o;
   logic [8:0]  host_addr_i = '0;
   logic [7:0]  host_data_i = '0;
   logic        host_we_i = 1'b0;
   logic [7:0]  host_data_o;
   logic [31:0] sd_lba_o;
   logic [1:0]  sd_rd_o, sd_wr_o;
   logic        sd_ack_i = 1'b0;
   logic [8:0]  sd_buff_addr_i = '0;
   logic [7:0]  sd_buff_dout_i = '0;
   logic        sd_buff_wr_i = 1'b0;
   logic [7:0]  sd_buff_din_o;

   int total = 0;
   int bad   = 0;

   always #5 clk_i = ~clk_i;

   sd_sector_client #(
      .DRIVE         (0),
      .TIMEOUT_CYCLES(24'd1000)
   ) dut (
      .clk_i         (clk_i),
      .reset_n_i     (reset_n_i),
      .req_rd_i      (req_rd_i),
      .req_wr_i      (req_wr_i),
      .lba_i         (lba_i),
      .busy_o        (busy_o),
      .done_o        (done_o),
      .err_o         (err_o),
      .host_addr_i   (host_addr_i),
      .host_data_i   (host_data_i),
      .host_we_i     (host_we_i),
      .host_data_o   (host_data_o),
      .sd_lba_o      (sd_lba_o),
      .sd_rd_o       (sd_rd_o),
      .sd_wr_o       (sd_wr_o),
      .sd_ack_i      (sd_ack_i),
      .sd_buff_addr_i(sd_buff_addr_i),
      .sd_buff_dout_i(sd_buff_dout_i),
      .sd_buff_wr_i  (sd_buff_wr_i),
      .sd_buff_din_o (sd_buff_din_o)
   );

   // All stimulus changes and samples happen 1 ns after the rising edge.
   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic host_read(input logic [8:0] a, output logic [7:0] v);
      host_addr_i = a;
      step();
      v = host_data_o;
   endtask

   // Bridge delivers bytes i^8'hA5 at addresses 0..nbytes-1, acking 5 cycles
   // after the request; reports what it observed.
   task automatic run_read(input logic [31:0] lba, input int nbytes,
                           output logic [1:0] rd_req, output logic [31:0] lba_seen,
                           output logic [1:0] rd_after_ack, output int pulses,
                           output logic err_at_done);
      req_rd_i = 1'b1;
      lba_i    = lba;
      step();
      req_rd_i = 1'b0;
      lba_seen = sd_lba_o;
      repeat (5) step();
      rd_req   = sd_rd_o;
      sd_ack_i = 1'b1;
      step();
      rd_after_ack = sd_rd_o;
      for (int i = 0; i < nbytes; i++) begin
         sd_buff_addr_i = 9'(i);
         sd_buff_dout_i = 8'(i) ^ 8'hA5;
         sd_buff_wr_i   = 1'b1;
         step();
      end
      sd_buff_wr_i = 1'b0;
      sd_ack_i     = 1'b0;
      pulses       = 0;
      err_at_done  = 1'bx;
      for (int c = 0; c < 4; c++) begin
         step();
         if (done_o === 1'b1) begin
            pulses++;
            err_at_done = err_o;
         end
      end
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk_i);
      #1;
      total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
      total++; if (done_o !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done_o); end
      total++; if (err_o !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", err_o); end
      total++; if ({sd_rd_o, sd_wr_o} !== 4'b0000) begin bad++; $display("FAIL reset_req got=%b exp=0000", {sd_rd_o, sd_wr_o}); end
      total++; if (sd_lba_o !== 32'h0) begin bad++; $display("FAIL reset_lba got=%h exp=0", sd_lba_o); end
      total++; if (host_data_o !== 8'h00) begin bad++; $display("FAIL reset_hdata got=%h exp=00", host_data_o); end
      reset_n_i = 1'b1;
      step();
   endtask

   task automatic test_read();
      logic [1:0] rq, ra; logic [31:0] l; int p; logic e; logic [7:0] v;
      run_read(32'h0000_0123, 512, rq, l, ra, p, e);
      total++; if (l !== 32'h123) begin bad++; $display("FAIL read_lba got=%h exp=00000123", l); end
      total++; if (rq !== 2'b01) begin bad++; $display("FAIL read_rd_req got=%b exp=01", rq); end
      total++; if (ra !== 2'b00) begin bad++; $display("FAIL read_rd_after_ack got=%b exp=00", ra); end
      total++; if (p !== 1) begin bad++; $display("FAIL read_done_pulses got=%0d exp=1", p); end
      total++; if (e !== 1'b0) begin bad++; $display("FAIL read_err got=%b exp=0", e); end
      total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL read_busy_after got=%b exp=0", busy_o); end
      host_read(9'h1FF, v);
      total++; if (v !== 8'h5A) begin bad++; $display("FAIL read_host_1ff got=%h exp=5a", v); end
      host_read(9'h000, v);
      total++; if (v !== 8'hA5) begin bad++; $display("FAIL read_host_000 got=%h exp=a5", v); end
   endtask

   task automatic test_write();
      logic [7:0] v;
      for (int i = 0; i < 512; i++) begin
         host_addr_i = 9'(i);
         host_data_i = 8'(i);
         host_we_i   = 1'b1;
         step();
      end
      host_we_i = 1'b0;
      req_wr_i  = 1'b1;
      lba_i     = 32'h0000_0456;
      step();
      req_wr_i = 1'b0;
      repeat (3) step();
      total++; if ({sd_rd_o, sd_wr_o} !== 4'b0001) begin bad++; $display("FAIL write_req got=%b exp=0001", {sd_rd_o, sd_wr_o}); end
      total++; if (sd_lba_o !== 32'h456) begin bad++; $display("FAIL write_lba got=%h exp=00000456", sd_lba_o); end
      sd_ack_i = 1'b1;
      step();
      total++; if (sd_wr_o !== 2'b00) begin bad++; $display("FAIL write_wr_after_ack got=%b exp=00", sd_wr_o); end
      sd_buff_addr_i = 9'h080;
      #1;
      total++; if (sd_buff_din_o !== 8'h80) begin bad++; $display("FAIL write_din_080 got=%h exp=80", sd_buff_din_o); end
      sd_buff_addr_i = 9'h1FF;
      #1;
      total++; if (sd_buff_din_o !== 8'hFF) begin bad++; $display("FAIL write_din_1ff got=%h exp=ff", sd_buff_din_o); end
      // A bridge strobe during a write command must not touch the buffer.
      sd_buff_addr_i = 9'h010;
      sd_buff_dout_i = 8'h00;
      sd_buff_wr_i   = 1'b1;
      step();
      sd_buff_wr_i = 1'b0;
      sd_ack_i     = 1'b0;
      step();
      total++; if (done_o !== 1'b1) begin bad++; $display("FAIL write_done got=%b exp=1", done_o); end
      total++; if (err_o !== 1'b0) begin bad++; $display("FAIL write_err got=%b exp=0", err_o); end
      step();
      total++; if (done_o !== 1'b0) begin bad++; $display("FAIL write_done_width got=%b exp=0", done_o); end
      host_read(9'h010, v);
      total++; if (v !== 8'h10) begin bad++; $display("FAIL write_strobe_ignored got=%h exp=10", v); end
   endtask

   task automatic test_short_read();
      logic [1:0] rq, ra; logic [31:0] l; int p; logic e;
      run_read(32'h0000_0077, 300, rq, l, ra, p, e);
      total++; if (p !== 1) begin bad++; $display("FAIL short_done_pulses got=%0d exp=1", p); end
      total++; if (e !== 1'b1) begin bad++; $display("FAIL short_err got=%b exp=1", e); end
   endtask

   task automatic test_priority_busy();
      logic [7:0] v;
      req_rd_i = 1'b1;
      req_wr_i = 1'b1;
      lba_i    = 32'h0000_0055;
      step();
      req_rd_i = 1'b0;
      req_wr_i = 1'b0;
      total++; if ({sd_rd_o, sd_wr_o} !== 4'b0100) begin bad++; $display("FAIL prio_req got=%b exp=0100", {sd_rd_o, sd_wr_o}); end
      total++; if (busy_o !== 1'b1) begin bad++; $display("FAIL prio_busy got=%b exp=1", busy_o); end
      sd_ack_i = 1'b1;
      step();
      for (int i = 0; i < 512; i++) begin
         sd_buff_addr_i = 9'(i);
         sd_buff_dout_i = 8'(i) ^ 8'hA5;
         sd_buff_wr_i   = 1'b1;
         step();
      end
      sd_buff_wr_i = 1'b0;
      req_wr_i     = 1'b1;
      host_addr_i  = 9'd5;
      host_data_i  = 8'hEE;
      host_we_i    = 1'b1;
      step();
      req_wr_i  = 1'b0;
      host_we_i = 1'b0;
      sd_ack_i  = 1'b0;
      step();
      total++; if ({done_o, err_o} !== 2'b10) begin bad++; $display("FAIL prio_done_err got=%b exp=10", {done_o, err_o}); end
      repeat (3) step();
      total++; if ({busy_o, sd_wr_o} !== 3'b000) begin bad++; $display("FAIL prio_no_queue got=%b exp=000", {busy_o, sd_wr_o}); end
      host_read(9'd5, v);
      total++; if (v !== 8'hA0) begin bad++; $display("FAIL prio_host_protect got=%h exp=a0", v); end
   endtask

   task automatic test_reset_mid();
      logic [1:0] rq, ra; logic [31:0] l; int p; logic e; logic [7:0] v;
      int seen_done;
      // Reset while the request line is high.
      req_rd_i = 1'b1;
      lba_i    = 32'h0000_0999;
      step();
      req_rd_i = 1'b0;
      #2 reset_n_i = 1'b0;
      #1;
      total++; if ({busy_o, sd_rd_o} !== 3'b000) begin bad++; $display("FAIL rst_req_async got=%b exp=000", {busy_o, sd_rd_o}); end
      step();
      reset_n_i = 1'b1;
      step();
      // Reset in XFER at byte 100.
      req_rd_i = 1'b1;
      step();
      req_rd_i = 1'b0;
      sd_ack_i = 1'b1;
      step();
      for (int i = 0; i < 100; i++) begin
         sd_buff_addr_i = 9'(i);
         sd_buff_dout_i = 8'h11;
         sd_buff_wr_i   = 1'b1;
         step();
      end
      #2 reset_n_i = 1'b0;
      #1;
      total++; if ({busy_o, sd_rd_o} !== 3'b000) begin bad++; $display("FAIL rst_xfer_async got=%b exp=000", {busy_o, sd_rd_o}); end
      seen_done = 0;
      sd_buff_wr_i = 1'b0;
      sd_ack_i     = 1'b0;
      for (int c = 0; c < 3; c++) begin
         step();
         if (done_o !== 1'b0) seen_done++;
      end
      reset_n_i = 1'b1;
      for (int c = 0; c < 3; c++) begin
         step();
         if (done_o !== 1'b0) seen_done++;
      end
      total++; if (seen_done !== 0) begin bad++; $display("FAIL rst_no_done got=%0d exp=0", seen_done); end
      run_read(32'h0000_0200, 512, rq, l, ra, p, e);
      total++; if ({p, e} !== {32'd1, 1'b0}) begin bad++; $display("FAIL rst_fresh_read pulses=%0d err=%b exp pulses=1 err=0", p, e); end
      host_read(9'h063, v);
      total++; if (v !== (8'h63 ^ 8'hA5)) begin bad++; $display("FAIL rst_fresh_data got=%h exp=%h", v, 8'h63 ^ 8'hA5); end
   endtask

`ifdef SD_SECTOR_CLIENT_TIMEOUT_EN
   task automatic test_timeout();
      int cnt;
      req_rd_i = 1'b1;
      lba_i    = 32'h0000_0321;
      step();
      req_rd_i = 1'b0;
      cnt = 0;
      while (done_o !== 1'b1 && cnt < 1100) begin
         step();
         cnt++;
      end
      total++; if (cnt !== 1000) begin bad++; $display("FAIL timeout_cycles got=%0d exp=1000", cnt); end
      total++; if ({err_o, sd_rd_o} !== 3'b100) begin bad++; $display("FAIL timeout_err_rd got=%b exp=100", {err_o, sd_rd_o}); end
      step();
   endtask
`endif

   initial begin
      test_reset();
      test_read();
      test_write();
      test_short_read();
      test_priority_busy();
      test_reset_mid();
`ifdef SD_SECTOR_CLIENT_TIMEOUT_EN
      test_timeout();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sd_sector_client.md
Name: sd_sector_client

Overview:
- Requester stage directly upstream of the SD-image/SRAM sector bridge.
- Accepts single-sector read/write commands from the FDC/CPU side and drives the `sd_lba`/`sd_rd`/`sd_wr` request lines on one drive slot.
- Tracks the `sd_ack` handshake and owns a 512-byte sector buffer.
- Read data arriving on `sd_buff_dout`/`sd_buff_wr` fills the buffer; write data is served to the bridge on `sd_buff_din`.

Parameters:
- DRIVE, 0, drive slot index (0 or 1); selects which bit of `sd_rd_o`/`sd_wr_o` is driven.
- TIMEOUT_CYCLES, 24'd8000000, watchdog limit in clk_i cycles, used only when the optional feature is compiled in.

Ports:
- clk_i  in  1  system clock
- reset_n_i  in  1  asynchronous active-low reset
- req_rd_i  in  1  one-cycle pulse: read sector lba_i into buffer
- req_wr_i  in  1  one-cycle pulse: write buffer to sector lba_i
- lba_i  in  32  sector number, sampled on the accepted request
- busy_o  out  1  high from request accept until done
- done_o  out  1  one-cycle pulse at end of command
- err_o  out  1  status of last command, valid at done_o; held until next accept
- host_addr_i  in  9  host buffer byte address
- host_data_i  in  8  host write data
- host_we_i  in  1  host buffer write strobe
- host_data_o  out  8  host read data, 1-cycle registered latency
- sd_lba_o  out  32  LBA presented to the bridge
- sd_rd_o  out  2  read request, bit DRIVE only
- sd_wr_o  out  2  write request, bit DRIVE only
- sd_ack_i  in  1  bridge acknowledge, high for the whole transfer
- sd_buff_addr_i  in  9  bridge buffer byte address
- sd_buff_dout_i  in  8  read data from the bridge
- sd_buff_wr_i  in  1  bridge write strobe for read data
- sd_buff_din_o  out  8  buffer byte at sd_buff_addr_i; combinational, same-cycle

Behaviour:
- Reset values: every output 0. State is IDLE, counters are 0, and the operation register is cleared. Buffer contents are not reset.
- Reset asserted mid-command:
  - Request lines and busy_o drop immediately.
  - No done_o pulse is produced.
- Buffer: 512x8 RAM.
  - Host port is synchronous read/write.
  - Bridge port is an asynchronous read for sd_buff_din_o, plus a synchronous write.
- States:
  - IDLE:
    - req_rd_i has priority; req_wr_i is accepted only if req_rd_i is low.
    - On accept: latch lba_i into sd_lba_o, latch the operation, set busy_o=1, clear err_o and byte_cnt, go to REQ.
  - REQ:
    - sd_rd_o[DRIVE] or sd_wr_o[DRIVE] is held high.
    - On sd_ack_i=1: drop the request line and go to XFER.
  - XFER:
    - For a read: every cycle with sd_buff_wr_i=1 writes sd_buff_dout_i to buffer[sd_buff_addr_i] and increments byte_cnt (10 bits).
    - For a write: sd_buff_wr_i is ignored.
    - On sd_ack_i=0 go to DONE.
  - DONE:
    - For a read: err_o = (byte_cnt != 512).
    - done_o pulses for one cycle, busy_o=0, go to IDLE.
- While busy_o=1:
  - host_we_i is ignored, so the buffer is protected.
  - Host reads remain allowed.
  - req_rd_i and req_wr_i are ignored, with no queueing.
- sd_buff_wr_i outside XFER, or during a write operation, is ignored.
- A read→done cycle costs 3 cycles beyond the bridge ack window: REQ exit, XFER exit, DONE.
- The unused drive bit of sd_rd_o/sd_wr_o is always 0.

Optional Feature:
- Macro: SD_SECTOR_CLIENT_TIMEOUT_EN.
- When defined:
  - A 24-bit watchdog counts cycles in REQ and XFER and clears on accept.
  - On reaching TIMEOUT_CYCLES: request lines drop, err_o=1, go to DONE, and done_o pulses.
  - A late sd_ack_i is then ignored until it returns low.
- When not defined: no counter, and the block waits indefinitely for sd_ack_i.

Test Plan:
- Read: req_rd_i with lba_i=32'h00000123. Bridge model acks after 5 cycles and writes bytes i^8'hA5 at addresses 0..511, then drops ack → sd_lba_o=32'h123, sd_rd_o=2'b01 until ack, done_o one pulse, err_o=0; host reads addr 0x1FF → 8'h5A.
- Write: host fills buffer with addr[7:0], then req_wr_i → sd_wr_o[0]=1 until ack; bridge samples sd_buff_din_o at addr 0x080 = 8'h80; done_o pulses, err_o=0.
- Short read: bridge delivers only 300 bytes before dropping ack → done_o with err_o=1.
- Priority/busy: req_rd_i and req_wr_i asserted in the same cycle → read performed. Second req_wr_i during XFER ignored; host_we_i to addr 5 during busy leaves the buffer unchanged.
- Reset mid-XFER: reset_n_i low at byte 100 → sd_rd_o=0 and busy_o=0 asynchronously, no done_o. After release, a fresh read completes normally.
- Timeout (macro defined, TIMEOUT_CYCLES=1000): ack never given → done_o at cycle 1000 after accept with err_o=1, sd_rd_o=0.
